// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first.
// Optional macro DIVIDER_ZERO_DETECT_EN short-circuits divide-by-zero and raises div_zero.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

`ifdef DIVIDER_ZERO_DETECT_EN
  localparam logic ZERO_DETECT = 1'b1;
`else
  localparam logic ZERO_DETECT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic             accept_s;
  logic             zero_fast_s;
  logic             ge_s;
  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   rem_step_s;
  logic [WIDTH-1:0] quo_step_s;

  assign accept_s    = start && (state_q != CALC);
  assign zero_fast_s = ZERO_DETECT && (divisor == {WIDTH{1'b0}});

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign rem_shift_s = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
  assign ge_s        = (rem_shift_s >= {1'b0, dsr_q});
  assign rem_step_s  = ge_s ? (rem_shift_s - {1'b0, dsr_q}) : rem_shift_s;
  assign quo_step_s  = (quo_q << 1) | {{(WIDTH-1){1'b0}}, ge_s};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = zero_fast_s ? DONE : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    busy_d      = (state_d == CALC);
    done_d      = (state_d == DONE);
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          dvd_d      = dividend;
          dsr_d      = divisor;
          quo_d      = {WIDTH{1'b0}};
          rem_d      = {(WIDTH+1){1'b0}};
          cnt_d      = CW'(WIDTH-1);
          div_zero_d = zero_fast_s;
          if (zero_fast_s) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
          end else begin
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
          end
        end else begin
          dvd_d = dvd_q;
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_step_s;
        quo_d = quo_step_s;
        if (cnt_q == {CW{1'b0}}) begin
          quotient_d  = quo_step_s;
          remainder_d = rem_step_s[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        dvd_d = dvd_q;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= {WIDTH{1'b0}};
      dsr_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      rem_q       <= {(WIDTH+1){1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: WIDTH=8 directed/random runs and a WIDTH=4 sweep.
module tb_restoring_divider;

`ifdef DIVIDER_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] dvd8 = 8'd0, dsr8 = 8'd0, q8, r8;
  logic [3:0] dvd4 = 4'd0, dsr4 = 4'd0, q4, r4;
  logic       busy8, done8, dz8, busy4, done4, dz4;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(dvd8), .divisor(dsr8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_zero(dz8)
  );

  restoring_divider #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dvd4), .divisor(dsr4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_zero(dz4)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        exp8[$];
  exp_t        exp4[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy_n8 = 0;
  logic [31:0] last_q8 = 32'd0;
  logic [31:0] last_r8 = 32'd0;
  logic        last_dz8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned divide/modulo; divide-by-zero gives all ones / dividend.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input int acc);
    exp_t e;
    e.acc = acc;
    if (b == 32'd0) begin
      e.q   = (32'd1 << w) - 32'd1;
      e.r   = a;
      e.dz  = ZD;
      e.lat = ZD ? 1 : w + 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 1'b0;
      e.lat = w + 1;
    end
    return e;
  endfunction

  // Issue a request; return at the negedge where its done pulse is visible.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit keep);
    exp_t e;
    start8 = 1'b1;
    dvd8   = a;
    dsr8   = b;
    e = model(8, {24'd0, a}, {24'd0, b}, cyc + 1);
    exp8.push_back(e);
    @(negedge clk);
    if (!keep) start8 = 1'b0;
    repeat (e.lat - 1) @(negedge clk);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    start4 = 1'b1;
    dvd4   = a;
    dsr4   = b;
    e = model(4, {28'd0, a}, {28'd0, b}, cyc + 1);
    exp4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    repeat (e.lat - 1) @(negedge clk);
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_n8  = 0;
      last_q8  = 32'd0;
      last_r8  = 32'd0;
      last_dz8 = 1'b0;
    end else begin
      if (busy8) busy_n8++;
      if (done8) begin
        if (exp8.size() == 0) begin
          chk("unexpected_done8", 32'd1, 32'd0);
        end else begin
          e = exp8.pop_front();
          chk("quotient8", {24'd0, q8}, e.q);
          chk("remainder8", {24'd0, r8}, e.r);
          chk("div_zero8", {31'd0, dz8}, {31'd0, e.dz});
          chk("latency8", cyc + 1 - e.acc, e.lat);
          chk("busy_cycles8", busy_n8, e.lat - 1);
          busy_n8  = 0;
          last_q8  = e.q;
          last_r8  = e.r;
          last_dz8 = e.dz;
        end
      end else if (!busy8) begin
        chk("hold_q8", {24'd0, q8}, last_q8);
        chk("hold_r8", {24'd0, r8}, last_r8);
        chk("hold_dz8", {31'd0, dz8}, {31'd0, last_dz8});
      end
    end
  end

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      if (exp4.size() == 0) begin
        chk("unexpected_done4", 32'd1, 32'd0);
      end else begin
        e = exp4.pop_front();
        chk("quotient4", {28'd0, q4}, e.q);
        chk("remainder4", {28'd0, r4}, e.r);
        chk("div_zero4", {31'd0, dz4}, {31'd0, e.dz});
        chk("latency4", cyc + 1 - e.acc, e.lat);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_q8", {24'd0, q8}, 32'd0);
    chk("rst_r8", {24'd0, r8}, 32'd0);
    chk("rst_dz8", {31'd0, dz8}, 32'd0);
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_done4", {31'd0, done4}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // 100/7 single run
    send8(8'd100, 8'd7, 1'b0);

    // back-to-back with start held through done
    send8(8'd255, 8'd1, 1'b1);
    send8(8'd5, 8'd9, 1'b1);
    start8 = 1'b0;
    @(negedge clk);

    // start pulsed during CALC must be ignored
    start8 = 1'b1; dvd8 = 8'd200; dsr8 = 8'd3;
    exp8.push_back(model(8, 32'd200, 32'd3, cyc + 1));
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd9; dsr8 = 8'd2;
    @(negedge clk); start8 = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);

    // asynchronous reset in the 4th CALC cycle aborts without a done pulse
    start8 = 1'b1; dvd8 = 8'd100; dsr8 = 8'd7;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk("abort_q8", {24'd0, q8}, 32'd0);
    chk("abort_r8", {24'd0, r8}, 32'd0);
    chk("abort_dz8", {31'd0, dz8}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    send8(8'd50, 8'd5, 1'b0);
    @(negedge clk);

    // divide by zero
    send8(8'd200, 8'd0, 1'b0);
    @(negedge clk);

    // randomized traffic with mixed gaps and held start
    for (int i = 0; i < 200; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      bit         keep;
      int         gap;
      a    = 8'($urandom);
      b    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      keep = 1'($urandom_range(0, 1));
      send8(a, b, keep);
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        start8 = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    start8 = 1'b0;
    @(negedge clk);

    // exhaustive 4-bit operand sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send4(4'(a), 4'(b));
      end
    end
    start4 = 1'b0;

    repeat (4) @(negedge clk);
    chk("pending8", exp8.size(), 32'd0);
    chk("pending4", exp4.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
